pipe_stage_reg: RTL

//  Generic parametrised inter-stage pipeline register (ID/EX and later stages) for the RV32I core.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_skid_buf.sv | 92 +++++++++
 rtl/pipe_stage_reg.sv | 74 +++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I inter-stage pipeline registers: bundle layout,
// derived bundle widths, default bubble kill mask and the skid-buffer state encoding.
package pipe_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PC_W     = 8;
  localparam int unsigned RF_IDX_W = 5;

  // Control bundle layout (bit offsets / field widths)
  localparam int unsigned CTRL_JUMP_BIT    = 0;
  localparam int unsigned CTRL_BRANCH_BIT  = 1;
  localparam int unsigned CTRL_WEN_RF_BIT  = 2;
  localparam int unsigned CTRL_EN_DMEM_BIT = 3;
  localparam int unsigned CTRL_WB_OFS      = 4;
  localparam int unsigned CTRL_WB_W        = 2;
  localparam int unsigned CTRL_FUNC_OFS    = 6;
  localparam int unsigned CTRL_FUNC_W      = 3;
  localparam int unsigned CTRL_ALU_OFS     = 9;
  localparam int unsigned CTRL_ALU_W       = 4;
  localparam int unsigned CTRL_DMEM_WE_BIT = 13;
  localparam int unsigned CTRL_IMM_OFS     = 14;
  localparam int unsigned CTRL_IMM_W       = 2;

  localparam int unsigned PIPE_CTRL_W = CTRL_IMM_OFS + CTRL_IMM_W;
  // rf1, rf2, imm, two PCs, rd/rs1/rs2
  localparam int unsigned PIPE_DATA_W = 3 * XLEN + 2 * PC_W + 3 * RF_IDX_W;

  // Bits whose spurious assertion in a bubble would change architectural state
  localparam logic [PIPE_CTRL_W-1:0] PIPE_KILL_MASK = PIPE_CTRL_W'(
      (1 << CTRL_JUMP_BIT) | (1 << CTRL_BRANCH_BIT) |
      (1 << CTRL_WEN_RF_BIT) | (1 << CTRL_EN_DMEM_BIT));

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry and occupancy FSM for pipe_stage_reg; tells the top when to load its main
// register (from the input or from the skid entry) and when to turn it into a bubble.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  input  logic [CTRL_W-1:0] inCtrl,
  input  logic [DATA_W-1:0] inData,
  input  logic              flush,
  input  logic              outValid,
  input  logic              outReady,
  output logic              inReady,
  output logic              mainLd,
  output logic              mainClr,
  output logic [CTRL_W-1:0] ldCtrl,
  output logic [DATA_W-1:0] ldData
);

  skid_state_e       state, stateNext;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;
  logic              skidLd;
  logic              inXfer, outXfer;

  assign inXfer  = inValid & inReady;
  assign outXfer = outValid & outReady;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the skid payload is reset too, so nothing undefined is ever muxed onto the main register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SKID_EMPTY;
      inReady  <= 1'b1;
      skidCtrl <= '0;
      skidData <= '0;
    end else begin
      state   <= stateNext;
      inReady <= (stateNext != SKID_TWO);
      if (skidLd) begin
        skidCtrl <= inCtrl;
        skidData <= inData;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    if (flush) begin
      stateNext = SKID_EMPTY;
    end else begin
      case (state)
        SKID_EMPTY: if (inXfer) stateNext = SKID_ONE;
        SKID_ONE: begin
          if (inXfer && !outXfer)      stateNext = SKID_TWO;
          else if (outXfer && !inXfer) stateNext = SKID_EMPTY;
        end
        SKID_TWO:   if (outXfer) stateNext = SKID_ONE;
        default:    stateNext = SKID_EMPTY;
      endcase
    end
  end

  // The skid entry always drains through the main register, which keeps order intact.
  always_comb begin
    mainLd  = 1'b0;
    mainClr = 1'b0;
    skidLd  = 1'b0;
    ldCtrl  = inCtrl;
    ldData  = inData;
    case (state)
      SKID_EMPTY: mainLd = inXfer;
      SKID_ONE: begin
        mainLd  = inXfer & outXfer;
        skidLd  = inXfer & ~outXfer & ~flush;
        mainClr = outXfer & ~inXfer;
      end
      SKID_TWO: begin
        mainLd = outXfer;
        ldCtrl = skidCtrl;
        ldData = skidData;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready stall, flush and bubble masking.
// Define PIPE_STAGE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W         = PIPE_CTRL_W,
  parameter int unsigned       DATA_W         = PIPE_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_KILL_MASK = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              mainLd;
  logic              mainClr;
  logic [CTRL_W-1:0] ldCtrl;
  logic [DATA_W-1:0] ldData;

`ifdef PIPE_STAGE_SKID_EN
  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (in_valid),
    .inCtrl   (in_ctrl),
    .inData   (in_data),
    .flush    (flush),
    .outValid (out_valid),
    .outReady (out_ready),
    .inReady  (in_ready),
    .mainLd   (mainLd),
    .mainClr  (mainClr),
    .ldCtrl   (ldCtrl),
    .ldData   (ldData)
  );
`else
  assign in_ready = out_ready | ~out_valid;
  assign mainLd   = in_valid & in_ready;
  assign mainClr  = out_valid & out_ready;
  assign ldCtrl   = in_ctrl;
  assign ldData   = in_data;
`endif

  // Flush beats everything; a bubble clears only the kill-mask bits and keeps the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= out_ctrl & ~CTRL_KILL_MASK;
    end else if (mainLd) begin
      out_valid <= 1'b1;
      out_ctrl  <= ldCtrl;
      out_data  <= ldData;
    end else if (mainClr) begin
      out_valid <= 1'b0;
      out_ctrl  <= out_ctrl & ~CTRL_KILL_MASK;
    end
  end

endmodule
